// File: rtl/adc_arb_pkg.sv
// Shared types, default parameters and helpers for the ADC sharing arbiter.
package adc_arb_pkg;

    typedef enum logic {StIdle, StConv} state_e;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned TO_W_DEF    = 16;

    // Encoder for up to eight one-hot bits; all-zero input maps to index 0.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap-around.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o,
    output logic [N-1:0]    onehot_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cand     = '0;
        // Walk offsets from far to near so the nearest requester is written last and wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IdxW'((32'(ptr_i) + 32'(i)) % N);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        if (valid_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/adc_share_arbiter.sv
// Round-robin arbiter sharing one ADC among N_REQ capture channels, with conversion timeout.
module adc_share_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic [N_REQ-1:0]  grant_o,
    output logic              adc_req,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_data,
    output logic              busy,
    input  logic              err_clr,
    output logic              timeout_err,
    output logic [2:0]        err_id,
    output logic [15:0]       conv_cnt
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [N_REQ-1:0]   rdy_q, rdy_d;
    logic               err_q, err_d;
    logic [2:0]         err_id_q, err_id_d;
    logic [15:0]        conv_cnt_q, conv_cnt_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [TO_W-1:0]    cnt_inc;
    logic [N_REQ-1:0]   deliver;

    rr_pick #(
        .N    (N_REQ),
        .IdxW (IDX_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    assign ptr_nxt = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    assign cnt_inc = cnt_q + TO_W'(1);
    // Only a channel still holding its request receives the sample.
    assign deliver = grant_q & req_i;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rdy_d      = '0;
        err_d      = err_q;
        err_id_d   = err_id_q;
        conv_cnt_d = conv_cnt_q;

        if (err_clr) err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StConv;
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            StConv: begin
                cnt_d = cnt_inc;
                if (adc_rdy) begin
                    if (|deliver) begin
                        data_d     = adc_data;
                        rdy_d      = deliver;
                        conv_cnt_d = conv_cnt_q + 16'd1;
                    end
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                end else if (cnt_inc == TO_W'(TIMEOUT)) begin
                    // Timeout outranks a same-cycle err_clr.
                    state_d  = StIdle;
                    grant_d  = '0;
                    ptr_d    = ptr_nxt;
                    err_d    = 1'b1;
                    err_id_d = onehot2idx(8'(grant_q));
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            rdy_q      <= '0;
            err_q      <= 1'b0;
            err_id_q   <= '0;
            conv_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            err_id_q   <= err_id_d;
            conv_cnt_q <= conv_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign adc_req     = (state_q == StConv);
    assign busy        = (state_q == StConv);
    assign rdy_o       = rdy_q;
    assign data_o      = data_q;
    assign timeout_err = err_q;
    assign err_id      = err_id_q;
    assign conv_cnt    = conv_cnt_q;

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Directed self-checking bench for adc_share_arbiter (N_REQ=4, DATA_W=8, TIMEOUT=8).
module tb_adc_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_i;
    logic [3:0]  rdy_o;
    logic [7:0]  data_o;
    logic [3:0]  grant_o;
    logic        adc_req;
    logic        adc_rdy;
    logic [7:0]  adc_data;
    logic        busy;
    logic        err_clr;
    logic        timeout_err;
    logic [2:0]  err_id;
    logic [15:0] conv_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    adc_share_arbiter #(
        .N_REQ   (4),
        .DATA_W  (8),
        .TIMEOUT (8),
        .TO_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .rdy_o       (rdy_o),
        .data_o      (data_o),
        .grant_o     (grant_o),
        .adc_req     (adc_req),
        .adc_rdy     (adc_rdy),
        .adc_data    (adc_data),
        .busy        (busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .err_id      (err_id),
        .conv_cnt    (conv_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_i    = '0;
        adc_rdy  = 1'b0;
        adc_data = '0;
        err_clr  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({grant_o, adc_req, busy, rdy_o} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {grant_o, adc_req, busy, rdy_o});
        end
        n_cmp++;
        if ({data_o, timeout_err, err_id, conv_cnt} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {data_o, timeout_err, err_id, conv_cnt});
        end
    endtask

    task automatic test_single();
        do_reset();
        req_i = 4'b0001;
        tick();
        n_cmp++;
        if ({grant_o, adc_req, busy} !== 6'b0001_11) begin
            n_bad++;
            $display("FAIL single_grant: got %b want 000111", {grant_o, adc_req, busy});
        end
        tick();
        tick();
        adc_rdy  = 1'b1;
        adc_data = 8'hA5;
        tick();
        adc_rdy = 1'b0;
        req_i   = 4'b0000;
        n_cmp++;
        if ({rdy_o, data_o} !== {4'b0001, 8'hA5}) begin
            n_bad++;
            $display("FAIL single_rdy: got %b/%h want 0001/a5", rdy_o, data_o);
        end
        n_cmp++;
        if ({conv_cnt, adc_req, grant_o} !== {16'd1, 1'b0, 4'b0000}) begin
            n_bad++;
            $display("FAIL single_done: got cnt=%0d req=%b g=%b want 1/0/0000",
                     conv_cnt, adc_req, grant_o);
        end
        tick();
        n_cmp++;
        if ({rdy_o, adc_req} !== 5'b0000_0) begin
            n_bad++;
            $display("FAIL single_pulse_end: got %b want 00000", {rdy_o, adc_req});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_d [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        do_reset();
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({grant_o, adc_req} !== {exp_g[k], 1'b1}) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got %b want %b", k, grant_o, exp_g[k]);
            end
            adc_rdy  = 1'b1;
            adc_data = exp_d[k];
            tick();
            adc_rdy = 1'b0;
            n_cmp++;
            if ({rdy_o, data_o, adc_req} !== {exp_g[k], exp_d[k], 1'b0}) begin
                n_bad++;
                $display("FAIL rr_rdy%0d: got %b/%h/%b want %b/%h/0",
                         k, rdy_o, data_o, adc_req, exp_g[k], exp_d[k]);
            end
        end
        req_i = 4'b0000;
        n_cmp++;
        if (conv_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL rr_count: got %0d want 5", conv_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_i = 4'b0100;
        tick();
        n_cmp++;
        if (grant_o !== 4'b0100) begin
            n_bad++;
            $display("FAIL to_grant: got %b want 0100", grant_o);
        end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if ({adc_req, timeout_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_still_conv: got %b want 10", {adc_req, timeout_err});
        end
        req_i = 4'b1100;
        tick();
        n_cmp++;
        if ({adc_req, timeout_err, err_id, rdy_o, grant_o} !== {2'b01, 3'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL to_fire: got req=%b err=%b id=%0d rdy=%b g=%b want 0/1/2/0000/0000",
                     adc_req, timeout_err, err_id, rdy_o, grant_o);
        end
        tick();
        n_cmp++;
        if (grant_o !== 4'b1000) begin
            n_bad++;
            $display("FAIL to_next_grant: got %b want 1000", grant_o);
        end
        req_i    = 4'b0000;
        err_clr  = 1'b1;
        adc_rdy  = 1'b1;
        adc_data = 8'h99;
        tick();
        err_clr = 1'b0;
        adc_rdy = 1'b0;
        n_cmp++;
        if ({timeout_err, err_id} !== {1'b0, 3'd2}) begin
            n_bad++;
            $display("FAIL to_clear: got err=%b id=%0d want 0/2", timeout_err, err_id);
        end
        n_cmp++;
        if ({rdy_o, data_o} !== 12'd0) begin
            n_bad++;
            $display("FAIL to_discard: got %b/%h want 0000/00", rdy_o, data_o);
        end
        // A timeout coinciding with err_clr must leave the flag set.
        req_i = 4'b0001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        req_i   = 4'b0000;
        n_cmp++;
        if ({timeout_err, err_id, adc_req} !== {1'b1, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL to_clr_race: got err=%b id=%0d req=%b want 1/0/0",
                     timeout_err, err_id, adc_req);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req_i = 4'b0001;
        tick();
        adc_rdy  = 1'b1;
        adc_data = 8'h3C;
        tick();
        adc_rdy = 1'b0;
        req_i   = 4'b0010;
        tick();
        n_cmp++;
        if (grant_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL drop_grant: got %b want 0010", grant_o);
        end
        req_i = 4'b0000;
        tick();
        adc_rdy  = 1'b1;
        adc_data = 8'h77;
        tick();
        adc_rdy = 1'b0;
        n_cmp++;
        if ({rdy_o, data_o, conv_cnt} !== {4'b0000, 8'h3C, 16'd1}) begin
            n_bad++;
            $display("FAIL drop_discard: got rdy=%b d=%h cnt=%0d want 0000/3c/1",
                     rdy_o, data_o, conv_cnt);
        end
        n_cmp++;
        if ({adc_req, grant_o} !== 5'b0_0000) begin
            n_bad++;
            $display("FAIL drop_release: got %b want 00000", {adc_req, grant_o});
        end
        req_i = 4'b1111;
        tick();
        req_i = 4'b0000;
        n_cmp++;
        if (grant_o !== 4'b0100) begin
            n_bad++;
            $display("FAIL drop_ptr: got %b want 0100", grant_o);
        end
    endtask

    task automatic test_rdy_at_timeout();
        do_reset();
        req_i = 4'b0001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        adc_rdy  = 1'b1;
        adc_data = 8'h5A;
        tick();
        adc_rdy = 1'b0;
        req_i   = 4'b0000;
        n_cmp++;
        if ({rdy_o, data_o, timeout_err} !== {4'b0001, 8'h5A, 1'b0}) begin
            n_bad++;
            $display("FAIL edge_rdy_wins: got rdy=%b d=%h err=%b want 0001/5a/0",
                     rdy_o, data_o, timeout_err);
        end
        n_cmp++;
        if (conv_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL edge_count: got %0d want 1", conv_cnt);
        end
    endtask

    task automatic test_reset_mid_conv();
        do_reset();
        req_i = 4'b0001;
        tick();
        adc_rdy  = 1'b1;
        adc_data = 8'hC3;
        tick();
        adc_rdy = 1'b0;
        req_i   = 4'b0011;
        tick();
        n_cmp++;
        if (grant_o !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_pre_grant: got %b want 0010", grant_o);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({grant_o, adc_req, busy, rdy_o, data_o, conv_cnt} !== 34'd0) begin
            n_bad++;
            $display("FAIL rst_mid_conv: got g=%b req=%b busy=%b rdy=%b d=%h cnt=%0d want 0",
                     grant_o, adc_req, busy, rdy_o, data_o, conv_cnt);
        end
        reset    = 1'b0;
        adc_rdy  = 1'b1;
        adc_data = 8'hEE;
        tick();
        adc_rdy = 1'b0;
        n_cmp++;
        if ({rdy_o, data_o, conv_cnt} !== 28'd0) begin
            n_bad++;
            $display("FAIL rst_late_rdy: got rdy=%b d=%h cnt=%0d want 0", rdy_o, data_o, conv_cnt);
        end
        n_cmp++;
        if (grant_o !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_ptr_zero: got %b want 0001", grant_o);
        end
        req_i = 4'b0000;
    endtask

    initial begin
        reset    = 1'b1;
        req_i    = '0;
        adc_rdy  = 1'b0;
        adc_data = '0;
        err_clr  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_drop();
        test_rdy_at_timeout();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
